// File: rtl/threedo_pkg.sv
// -----------------------------------------------------------------------------
// threedo_pkg
// Shared constants for the 3DO controller daisy-chain emulation:
//   - FSM state encoding (IDLE / LATCH / SHIFT / DONE)
//   - default report width per pad
//   - maximum number of pads that can share one chain
// -----------------------------------------------------------------------------
package threedo_pkg;

    localparam int BITS_DEFAULT = 16;
    localparam int NUM_PADS_MAX = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/threedo_sync2.sv
// -----------------------------------------------------------------------------
// threedo_sync2
// Two-flop synchronizer bringing one console-domain signal into the
// system_clock domain.
// Ports:
//   system_clock  in   sole clock, rising edge
//   reset         in   synchronous, active-high; clears both flops
//   d             in   asynchronous input
//   q             out  synchronized output (two cycles of latency)
// -----------------------------------------------------------------------------
module threedo_sync2 (
    input  logic system_clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/threedo_chain_sched.sv
// -----------------------------------------------------------------------------
// threedo_chain_sched
// Serialises up to four USB pad reports onto a single 3DO controller daisy
// chain. The console raises ps to latch, then clocks bits out on clk; each
// present pad contributes BITS bits, lowest pad index first, MSB first.
// Absent pads are skipped entirely so the console sees a shorter chain.
//
// Ports:
//   system_clock  in   sole clock, rising edge
//   reset         in   synchronous, active-high
//   ps            in   console latch strobe (asynchronous)
//   clk           in   console shift clock (asynchronous)
//   pad_data      in   NUM_PADS*BITS pad reports, pad 0 in [BITS-1:0], 1=pressed
//   pad_present   in   per-pad connected flags
//   dat           out  registered serial data, active-low buttons
//   frame_start   out  one-cycle pulse as the SHIFT phase begins
//   busy          out  high while in LATCH or SHIFT
//
// Optional build macro THREEDO_SHIFT_TIMEOUT_EN adds a watchdog that abandons
// a SHIFT after TIMEOUT_CYCLES system_clock cycles without a console clk edge.
// -----------------------------------------------------------------------------
module threedo_chain_sched
    import threedo_pkg::*;
#(
    parameter int BITS           = BITS_DEFAULT,
    parameter int NUM_PADS       = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     ps,
    input  logic                     clk,
    input  logic [NUM_PADS*BITS-1:0] pad_data,
    input  logic [NUM_PADS-1:0]      pad_present,
    output logic                     dat,
    output logic                     frame_start,
    output logic                     busy
);

    localparam int W     = NUM_PADS * BITS;
    localparam int CNT_W = $clog2(W + 1);

    generate
        if (NUM_PADS < 1 || NUM_PADS > NUM_PADS_MAX || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("threedo_chain_sched: NUM_PADS or TIMEOUT_CYCLES out of range");
        end
    endgenerate

    logic             sps;
    logic             sclk;
    logic             sclk_prev;
    logic             clk_rise;
    logic [1:0]       state;
    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     compact;
    logic [CNT_W-1:0] load_count;

    // ---- console-domain inputs into system_clock domain ----
    threedo_sync2 u_sync_ps (
        .system_clock (system_clock),
        .reset        (reset),
        .d            (ps),
        .q            (sps)
    );

    threedo_sync2 u_sync_clk (
        .system_clock (system_clock),
        .reset        (reset),
        .d            (clk),
        .q            (sclk)
    );

    assign clk_rise = sclk & ~sclk_prev;
    assign busy     = (state == ST_LATCH) || (state == ST_SHIFT);

    // Walking pads from the highest index down, each present pad is pushed in
    // at the top and everything earlier slides down by BITS; the lowest present
    // index ends up in the MSBs, with unused low bits left at zero.
    always_comb begin
        logic [W-1:0] ext;
        compact    = '0;
        load_count = '0;
        ext        = '0;
        for (int k = NUM_PADS - 1; k >= 0; k--) begin
            if (pad_present[k]) begin
                ext             = '0;
                ext[BITS-1:0]   = pad_data[k*BITS +: BITS];
                compact         = (compact >> BITS) | (ext << (W - BITS));
                load_count      = load_count + CNT_W'(BITS);
            end
        end
    end

`ifdef THREEDO_SHIFT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd;
    logic            wd_expired;

    assign wd_expired = (wd >= WD_LIMIT);

    // Counts idle SHIFT cycles since the frame began or the last console edge.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            wd <= '0;
        end else if (state == ST_LATCH || clk_rise) begin
            wd <= '0;
        end else if (state == ST_SHIFT && !wd_expired) begin
            wd <= wd + WD_W'(1);
        end
    end
`endif

    // ---- scheduler FSM, shift register and registered output ----
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            count       <= '0;
            dat         <= 1'b1;
            frame_start <= 1'b0;
            sclk_prev   <= 1'b0;
        end else begin
            sclk_prev   <= sclk;
            frame_start <= 1'b0;
            // dat reflects the current register, so it trails each shift by a cycle.
            dat         <= (state == ST_SHIFT && count != '0) ? ~shreg[W-1] : 1'b1;

            if (state == ST_LATCH) begin
                // Reload on every LATCH cycle so the frame holds the newest reports.
                shreg <= compact;
                count <= load_count;
                if (sps) begin
                    state <= ST_LATCH;
                end else begin
                    state       <= ST_SHIFT;
                    frame_start <= 1'b1;
                end
            end else if (sps) begin
                state <= ST_LATCH;
            end else if (state == ST_SHIFT) begin
                if (count == '0) begin
                    state <= ST_DONE;
                end else if (clk_rise) begin
                    shreg <= shreg << 1;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
`ifdef THREEDO_SHIFT_TIMEOUT_EN
                else if (wd_expired) begin
                    state <= ST_IDLE;
                    dat   <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_threedo_chain_sched.sv
// -----------------------------------------------------------------------------
// tb_threedo_chain_sched
// Directed scenarios for the 3DO chain scheduler. Each console clk pulse
// queues the dat value the console should see at that rising edge; a monitor
// pops and compares at every clk rising edge.
// -----------------------------------------------------------------------------
module tb_threedo_chain_sched;
    import threedo_pkg::*;

    localparam int BITS     = 16;
    localparam int NUM_PADS = 2;

    logic                     system_clock = 1'b0;
    logic                     reset;
    logic                     ps;
    logic                     clk_c;
    logic [NUM_PADS*BITS-1:0] pad_data;
    logic [NUM_PADS-1:0]      pad_present;
    logic                     dat;
    logic                     frame_start;
    logic                     busy;

    always #5 system_clock = ~system_clock;

    threedo_chain_sched #(
        .BITS           (BITS),
        .NUM_PADS       (NUM_PADS),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .ps           (ps),
        .clk          (clk_c),
        .pad_data     (pad_data),
        .pad_present  (pad_present),
        .dat          (dat),
        .frame_start  (frame_start),
        .busy         (busy)
    );

    typedef struct {
        string name;
        logic  exp;
    } exp_t;

    exp_t sbq[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fs_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: console samples dat on its clk rising edge.
    always @(posedge clk_c) begin
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_unexpected_clk", 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            check(e.name, 32'(dat), 32'(e.exp));
        end
    end

    always @(negedge system_clock) begin
        if (frame_start === 1'b1) fs_count++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic ps_pulse();
        ps = 1'b1;
        wait_cyc(6);
        ps = 1'b0;
        wait_cyc(8);
    endtask

    task automatic clk_pulse(input string name, input logic exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
        clk_c = 1'b1;
        wait_cyc(8);
        clk_c = 1'b0;
        wait_cyc(8);
    endtask

    task automatic send_frame(input string name, input logic [31:0] expv, input int n);
        for (int i = 0; i < n; i++) begin
            clk_pulse($sformatf("%s[%0d]", name, i), expv[n-1-i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset       = 1'b1;
        ps          = 1'b0;
        clk_c       = 1'b0;
        pad_data    = '0;
        pad_present = '0;
        wait_cyc(3);
        check("rst_dat",         32'(dat),         32'd1);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_state",       32'(dut.state),   32'(ST_IDLE));
        reset = 1'b0;
        wait_cyc(2);

        // Two pads present: 8001 then 0003, inverted on the wire.
        pad_present = 2'b11;
        pad_data    = {16'h0003, 16'h8001};
        fs_count    = 0;
        ps_pulse();
        check("s1_frame_start_cnt", 32'(fs_count), 32'd1);
        check("s1_busy_shift",      32'(busy),     32'd1);
        send_frame("s1_dat", 32'h7FFE_FFFC, 32);
        wait_cyc(4);
        check("s1_dat_after", 32'(dat),       32'd1);
        check("s1_busy_done", 32'(busy),      32'd0);
        check("s1_state",     32'(dut.state), 32'(ST_DONE));

        // Only pad 1 present; pad 0 must never appear. Presence changes after
        // the latch must not disturb the frame.
        pad_present = 2'b10;
        pad_data    = {16'hC000, 16'hFFFF};
        ps_pulse();
        pad_present = 2'b11;
        pad_data    = '0;
        send_frame("s2_dat", 32'h0000_3FFF, 16);
        clk_pulse("s2_after_done", 1'b1);
        check("s2_dat_after", 32'(dat),       32'd1);
        check("s2_state",     32'(dut.state), 32'(ST_DONE));

        // No pads present: empty frame.
        pad_present = 2'b00;
        fs_count    = 0;
        ps_pulse();
        check("s3_frame_start_cnt", 32'(fs_count),  32'd1);
        check("s3_state",           32'(dut.state), 32'(ST_DONE));
        send_frame("s3_dat", 32'h0000_0007, 3);
        check("s3_state_after", 32'(dut.state), 32'(ST_DONE));

        // Abort after 5 shifts with a fresh latch carrying new data.
        pad_present = 2'b11;
        pad_data    = {16'h1234, 16'hA5A5};
        ps_pulse();
        send_frame("s4_pre", 32'h0000_000B, 5);
        pad_data = {16'hF0F0, 16'h0F0F};
        fs_count = 0;
        ps       = 1'b1;
        wait_cyc(4);
        check("s4_state_latch", 32'(dut.state), 32'(ST_LATCH));
        wait_cyc(2);
        ps = 1'b0;
        wait_cyc(8);
        check("s4_frame_start_cnt", 32'(fs_count), 32'd1);
        send_frame("s4_post", 32'hF0F0_0F0F, 32);

        // Reset mid-SHIFT, later clk pulses ignored until ps.
        pad_present = 2'b11;
        pad_data    = {16'h0000, 16'h5555};
        ps_pulse();
        send_frame("s5_pre", 32'h0000_0005, 3);
        reset = 1'b1;
        wait_cyc(1);
        check("s5_rst_dat",         32'(dat),         32'd1);
        check("s5_rst_busy",        32'(busy),        32'd0);
        check("s5_rst_frame_start", 32'(frame_start), 32'd0);
        reset = 1'b0;
        wait_cyc(2);
        send_frame("s5_ignored", 32'h0000_0007, 3);
        check("s5_state_idle", 32'(dut.state), 32'(ST_IDLE));
        ps_pulse();
        send_frame("s5_restart", 32'h0000_000A, 4);

`ifdef THREEDO_SHIFT_TIMEOUT_EN
        begin
            int   n;
            exp_t e;
            pad_present = 2'b11;
            pad_data    = {16'h0000, 16'h0000};
            ps_pulse();
            send_frame("s6_pre", 32'h0000_0007, 3);
            e.name = "s6_last";
            e.exp  = 1'b1;
            sbq.push_back(e);
            clk_c = 1'b1;
            n     = 0;
            while (busy === 1'b1 && n < 300) begin
                @(negedge system_clock);
                n++;
                if (n == 8) clk_c = 1'b0;
            end
            clk_c = 1'b0;
            check("s6_busy_fell",   32'(busy), 32'd0);
            check("s6_window_lo",   32'(n >= 95),  32'd1);
            check("s6_window_hi",   32'(n <= 110), 32'd1);
            wait_cyc(2);
            check("s6_dat",         32'(dat), 32'd1);
        end
`endif

        wait_cyc(4);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
